// File: rtl/battle_sequencer_if.sv
// Phase-handshake bundle between the battle sequencer (master) and the
// video timing, start button and phase responders (slave).
interface battle_sequencer_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        start_in;
  logic        player_finished_in;
  logic [7:0]  player_damage_in;
  logic        enemy_finished_in;
  logic [7:0]  enemy_damage_in;
  logic [3:0]  state_out;
  logic [7:0]  player_hp_out;
  logic [7:0]  enemy_hp_out;
  logic [7:0]  turn_count_out;
  logic        error_out;

  modport master (
    input  hcount_in, vcount_in, start_in,
    input  player_finished_in, player_damage_in,
    input  enemy_finished_in, enemy_damage_in,
    output state_out, player_hp_out, enemy_hp_out, turn_count_out, error_out
  );

  modport slave (
    output hcount_in, vcount_in, start_in,
    output player_finished_in, player_damage_in,
    output enemy_finished_in, enemy_damage_in,
    input  state_out, player_hp_out, enemy_hp_out, turn_count_out, error_out
  );
endinterface

// File: rtl/battle_sequencer.sv
// Battle turn controller: sequences player/enemy attack phases on frame
// ticks, applies reported damage to HP and decides win/lose.
// Optional macro BATTLE_TIMEOUT_EN adds a per-phase frame watchdog that
// sends the FSM to a sticky ERROR state.
module battle_sequencer #(
  parameter logic [7:0] PLAYER_HP_INIT = 8'd100,
  parameter logic [7:0] ENEMY_HP_INIT  = 8'd100,
  parameter int         TIMEOUT_FRAMES = 600
) (
  input  logic              clk,
  input  logic              rst,
  battle_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_PLAYER = 4'b0001,
    S_ENEMY  = 4'b0010,
    S_CHECK  = 4'b0011,
    S_WIN    = 4'b0100,
    S_LOSE   = 4'b0101,
    S_ERROR  = 4'b1111
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_php, w_php_nxt;
  logic [7:0] r_ehp, w_ehp_nxt;
  logic [7:0] r_turn, w_turn_nxt;
  logic       r_start_prev;
  logic       r_arm, w_arm_nxt;
  logic       r_last_player, w_last_player_nxt;  // 1: last phase was PLAYER

  logic w_start_edge, w_tick, w_in_phase, w_fin, w_accept;

`ifdef BATTLE_TIMEOUT_EN
  localparam int FW = ($clog2(TIMEOUT_FRAMES + 1) > 10) ? $clog2(TIMEOUT_FRAMES + 1) : 10;
  localparam logic [FW-1:0] TO_LIM = FW'(TIMEOUT_FRAMES);
  logic [FW-1:0] r_frames, w_frames_nxt;
  logic          r_err, w_err_nxt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_FRAMES > 0);
`endif

  assign w_start_edge = bus.start_in & ~r_start_prev;
  assign w_tick       = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
  assign w_in_phase   = (r_state == S_PLAYER) || (r_state == S_ENEMY);
  assign w_fin        = (r_state == S_PLAYER) ? bus.player_finished_in : bus.enemy_finished_in;
  // arm is only set after seeing the flag low, so a stale flag is never taken
  assign w_accept     = w_in_phase & r_arm & w_fin;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_php         <= PLAYER_HP_INIT;
      r_ehp         <= ENEMY_HP_INIT;
      r_turn        <= 8'd0;
      r_start_prev  <= 1'b1;
      r_arm         <= 1'b0;
      r_last_player <= 1'b0;
`ifdef BATTLE_TIMEOUT_EN
      r_frames      <= '0;
      r_err         <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_php         <= w_php_nxt;
      r_ehp         <= w_ehp_nxt;
      r_turn        <= w_turn_nxt;
      r_start_prev  <= bus.start_in;
      r_arm         <= w_arm_nxt;
      r_last_player <= w_last_player_nxt;
`ifdef BATTLE_TIMEOUT_EN
      r_frames      <= w_frames_nxt;
      r_err         <= w_err_nxt;
`endif
    end
  end

  // Next-state, HP update and phase bookkeeping
  always_comb begin
    w_state_nxt       = r_state;
    w_php_nxt         = r_php;
    w_ehp_nxt         = r_ehp;
    w_turn_nxt        = r_turn;
    w_arm_nxt         = r_arm;
    w_last_player_nxt = r_last_player;
`ifdef BATTLE_TIMEOUT_EN
    w_frames_nxt      = r_frames;
    w_err_nxt         = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_php_nxt         = PLAYER_HP_INIT;
          w_ehp_nxt         = ENEMY_HP_INIT;
          w_turn_nxt        = 8'd0;
          w_last_player_nxt = 1'b0;
          w_state_nxt       = S_CHECK;
        end
      end
      S_PLAYER, S_ENEMY: begin
        if (!w_fin) w_arm_nxt = 1'b1;
        if (w_accept) begin
          if (r_state == S_PLAYER) begin
            w_ehp_nxt         = (bus.player_damage_in >= r_ehp) ? 8'd0 : r_ehp - bus.player_damage_in;
            w_last_player_nxt = 1'b1;
          end else begin
            w_php_nxt         = (bus.enemy_damage_in >= r_php) ? 8'd0 : r_php - bus.enemy_damage_in;
            w_last_player_nxt = 1'b0;
            w_turn_nxt        = (r_turn == 8'hFF) ? 8'hFF : r_turn + 8'd1;
          end
          w_state_nxt = S_CHECK;
        end
`ifdef BATTLE_TIMEOUT_EN
        else begin
          // accept has priority over an expiring watchdog
          w_frames_nxt = r_frames + {{(FW-1){1'b0}}, w_tick};
          if (w_frames_nxt >= TO_LIM) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = 1'b1;
          end
        end
`endif
      end
      S_CHECK: begin
        if (r_ehp == 8'd0)      w_state_nxt = S_WIN;
        else if (r_php == 8'd0) w_state_nxt = S_LOSE;
        else if (w_tick) begin
          w_state_nxt = r_last_player ? S_ENEMY : S_PLAYER;
          w_arm_nxt   = 1'b0;
`ifdef BATTLE_TIMEOUT_EN
          w_frames_nxt = '0;
`endif
        end
      end
      S_WIN, S_LOSE: begin
        if (w_start_edge) w_state_nxt = S_IDLE;
      end
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.state_out      = r_state;
  assign bus.player_hp_out  = r_php;
  assign bus.enemy_hp_out   = r_ehp;
  assign bus.turn_count_out = r_turn;
`ifdef BATTLE_TIMEOUT_EN
  assign bus.error_out      = r_err;
`else
  assign bus.error_out      = 1'b0;
`endif

endmodule

// File: tb/tb_battle_sequencer.sv
// Self-checking bench for battle_sequencer: directed reset/handshake
// sequences, a table of single-turn outcomes, a saturation loop and
// randomized games checked against a game-level HP model.
module tb_battle_sequencer;

  localparam int ST_IDLE = 0, ST_PLAYER = 1, ST_ENEMY = 2, ST_CHECK = 3,
                 ST_WIN = 4, ST_LOSE = 5, ST_ERROR = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  battle_sequencer_if bif();

  battle_sequencer #(.PLAYER_HP_INIT(8'd100), .ENEMY_HP_INIT(8'd100), .TIMEOUT_FRAMES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pdmg;
    int edmg;
    int exp_ehp;
    int exp_php;
    int exp_state;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    bif.hcount_in = 11'd0;
    bif.vcount_in = 10'd0;
    step();
    bif.hcount_in = 11'd1;
  endtask

  task automatic press();
    bif.start_in = 1'b1;
    step();
    bif.start_in = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Leaves the DUT in CHECK right after a fresh game start.
  task automatic new_game();
    if (bif.state_out == 4'(ST_WIN) || bif.state_out == 4'(ST_LOSE)) press();
    else if (bif.state_out != 4'(ST_IDLE)) do_reset();
    press();
    chk("new_game_state", int'(bif.state_out), ST_CHECK);
  endtask

  task automatic play_player(input int d, input int delay);
    frame_tick();
    chk("player_entry", int'(bif.state_out), ST_PLAYER);
    bif.player_finished_in = 1'b0;
    repeat (delay + 1) step();
    bif.player_finished_in = 1'b1;
    bif.player_damage_in   = 8'(d);
    step();
    bif.player_finished_in = 1'b0;
    bif.player_damage_in   = 8'($urandom);
    chk("player_accept", int'(bif.state_out), ST_CHECK);
  endtask

  task automatic play_enemy(input int d, input int delay);
    frame_tick();
    chk("enemy_entry", int'(bif.state_out), ST_ENEMY);
    bif.enemy_finished_in = 1'b0;
    repeat (delay + 1) step();
    bif.enemy_finished_in = 1'b1;
    bif.enemy_damage_in   = 8'(d);
    step();
    bif.enemy_finished_in = 1'b0;
    bif.enemy_damage_in   = 8'($urandom);
    chk("enemy_accept", int'(bif.state_out), ST_CHECK);
  endtask

  function automatic int sat_sub(input int hp, input int d);
    return (d >= hp) ? 0 : hp - d;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int php, ehp, turns, d;

    bif.hcount_in = 11'd1;
    bif.vcount_in = 10'd0;
    bif.start_in = 1'b1;
    bif.player_finished_in = 1'b0;
    bif.player_damage_in = 8'd0;
    bif.enemy_finished_in = 1'b0;
    bif.enemy_damage_in = 8'd0;

    // Reset with start held: no game may start
    step(); step();
    chk("rst_state", int'(bif.state_out), ST_IDLE);
    chk("rst_php", int'(bif.player_hp_out), 100);
    chk("rst_ehp", int'(bif.enemy_hp_out), 100);
    chk("rst_turn", int'(bif.turn_count_out), 0);
    chk("rst_err", int'(bif.error_out), 0);
    rst = 1'b0;
    repeat (3) step();
    chk("held_start_no_game", int'(bif.state_out), ST_IDLE);
    bif.start_in = 1'b0;
    step();
    chk("release_idle", int'(bif.state_out), ST_IDLE);
    bif.start_in = 1'b1;
    step();
    chk("start_edge_check", int'(bif.state_out), ST_CHECK);
    bif.start_in = 1'b0;
    step();
    chk("check_waits_tick", int'(bif.state_out), ST_CHECK);

    // Stale finished flag from before entry must not be accepted
    bif.player_finished_in = 1'b1;
    bif.player_damage_in = 8'd99;
    frame_tick();
    chk("first_phase_player", int'(bif.state_out), ST_PLAYER);
    repeat (3) step();
    chk("stale_flag_ignored", int'(bif.state_out), ST_PLAYER);
    chk("stale_no_damage", int'(bif.enemy_hp_out), 100);
    bif.player_finished_in = 1'b0;
    step();
    bif.player_finished_in = 1'b1;
    bif.player_damage_in = 8'd30;
    step();
    bif.player_finished_in = 1'b0;
    chk("p30_state", int'(bif.state_out), ST_CHECK);
    chk("p30_ehp", int'(bif.enemy_hp_out), 70);
    step();
    chk("p30_check_hold", int'(bif.state_out), ST_CHECK);

    // Overkill enemy damage -> LOSE
    play_enemy(250, 0);
    chk("e250_php", int'(bif.player_hp_out), 0);
    chk("e250_turn", int'(bif.turn_count_out), 1);
    step();
    chk("lose_state", int'(bif.state_out), ST_LOSE);
    press();
    chk("lose_to_idle", int'(bif.state_out), ST_IDLE);
    chk("idle_hp_kept", int'(bif.player_hp_out), 0);

    // Exact kill -> WIN, HP held after returning to IDLE
    new_game();
    chk("ng_php", int'(bif.player_hp_out), 100);
    chk("ng_turn", int'(bif.turn_count_out), 0);
    play_player(100, 1);
    chk("p100_ehp", int'(bif.enemy_hp_out), 0);
    step();
    chk("win_state", int'(bif.state_out), ST_WIN);
    repeat (2) step();
    chk("win_hold", int'(bif.state_out), ST_WIN);
    press();
    chk("win_to_idle", int'(bif.state_out), ST_IDLE);
    chk("win_idle_ehp", int'(bif.enemy_hp_out), 0);

    // Single-turn outcome table
    vecs[0] = '{0,   0,   100, 100, ST_CHECK};
    vecs[1] = '{30,  45,  70,  55,  ST_CHECK};
    vecs[2] = '{99,  100, 1,   0,   ST_LOSE};
    vecs[3] = '{100, 0,   0,   100, ST_WIN};
    vecs[4] = '{255, 7,   0,   100, ST_WIN};
    vecs[5] = '{1,   255, 99,  0,   ST_LOSE};
    vecs[6] = '{50,  99,  50,  1,   ST_CHECK};
    for (int i = 0; i < 7; i++) begin
      new_game();
      play_player(vecs[i].pdmg, i % 3);
      if (vecs[i].exp_ehp != 0) play_enemy(vecs[i].edmg, (i + 1) % 3);
      step();
      chk($sformatf("vec%0d_state", i), int'(bif.state_out), vecs[i].exp_state);
      chk($sformatf("vec%0d_ehp", i), int'(bif.enemy_hp_out), vecs[i].exp_ehp);
      chk($sformatf("vec%0d_php", i), int'(bif.player_hp_out), vecs[i].exp_php);
    end

    // Zero-damage game: turn counter saturates, HP untouched
    new_game();
    for (int t = 0; t < 300; t++) begin
      play_player(0, 0);
      play_enemy(0, 0);
    end
    chk("sat_turn", int'(bif.turn_count_out), 255);
    chk("sat_php", int'(bif.player_hp_out), 100);
    chk("sat_ehp", int'(bif.enemy_hp_out), 100);

    // Randomized games against a game-level HP model
    for (int g = 0; g < 15; g++) begin
      new_game();
      php = 100; ehp = 100; turns = 0;
      for (int t = 0; t < 30; t++) begin
        repeat ($urandom_range(0, 2)) step();
        d = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 40);
        play_player(d, $urandom_range(0, 3));
        ehp = sat_sub(ehp, d);
        chk("rnd_ehp", int'(bif.enemy_hp_out), ehp);
        step();
        if (ehp == 0) begin
          chk("rnd_win", int'(bif.state_out), ST_WIN);
          break;
        end
        chk("rnd_check_p", int'(bif.state_out), ST_CHECK);
        d = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 40);
        play_enemy(d, $urandom_range(0, 3));
        php = sat_sub(php, d);
        turns = (turns < 255) ? turns + 1 : 255;
        chk("rnd_php", int'(bif.player_hp_out), php);
        chk("rnd_turn", int'(bif.turn_count_out), turns);
        step();
        if (php == 0) begin
          chk("rnd_lose", int'(bif.state_out), ST_LOSE);
          break;
        end
        chk("rnd_check_e", int'(bif.state_out), ST_CHECK);
      end
    end

`ifdef BATTLE_TIMEOUT_EN
    // Phase watchdog: third frame tick inside the phase trips ERROR
    new_game();
    frame_tick();
    chk("to_entry", int'(bif.state_out), ST_PLAYER);
    step();
    frame_tick();
    frame_tick();
    chk("to_not_yet", int'(bif.state_out), ST_PLAYER);
    chk("to_err_low", int'(bif.error_out), 0);
    frame_tick();
    chk("to_error_state", int'(bif.state_out), ST_ERROR);
    chk("to_error_flag", int'(bif.error_out), 1);
    press();
    chk("to_start_ignored", int'(bif.state_out), ST_ERROR);
    chk("to_err_sticky", int'(bif.error_out), 1);
    do_reset();
    chk("to_rst_state", int'(bif.state_out), ST_IDLE);
    chk("to_rst_err", int'(bif.error_out), 0);
`else
    // Without the watchdog a phase waits through any number of frames
    new_game();
    frame_tick();
    chk("nto_entry", int'(bif.state_out), ST_PLAYER);
    step();
    repeat (6) frame_tick();
    chk("nto_wait", int'(bif.state_out), ST_PLAYER);
    chk("nto_err", int'(bif.error_out), 0);
    bif.player_finished_in = 1'b1;
    bif.player_damage_in = 8'd10;
    step();
    bif.player_finished_in = 1'b0;
    chk("nto_accept", int'(bif.state_out), ST_CHECK);
    chk("nto_ehp", int'(bif.enemy_hp_out), 90);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
